// File: rtl/sense_pkg.sv
// sense_pkg: FSM state encoding and default timing/vote constants for the sense cycle scheduler.
package sense_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    ECHO_WAIT = 3'd2,
    ECHO_MEAS = 3'd3,
    FRAME     = 3'd4,
    INFER     = 3'd5,
    VOTE      = 3'd6
  } state_t;
  localparam int CNT_W             = 21;
  localparam int PERIOD_DEF        = 1500000;
  localparam int TRIG_CYCLES_DEF   = 250;
  localparam int ECHO_TIMEOUT_DEF  = 60000;
  localparam int FRAME_TIMEOUT_DEF = 1048575;
  localparam int DIST_SHIFT_DEF    = 10;
  localparam int VOTE_DEPTH_DEF    = 4;
  localparam int VOTE_THRESH_DEF   = 3;
endpackage

// File: rtl/majority_vote_filter.sv
// majority_vote_filter: N-of-M vote over a shifted prediction history.
module majority_vote_filter
  import sense_pkg::*;
#(
  parameter int DEPTH  = VOTE_DEPTH_DEF,
  parameter int THRESH = VOTE_THRESH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic shift,
  input  logic bit_in,
  output logic result,
  output logic result_next
);
  localparam int OW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] hist, hist_next;
  logic [OW-1:0] ones;
  always_comb begin
    hist_next = {hist[DEPTH-2:0], bit_in};
    ones = '0;
    for (int i = 0; i < DEPTH; i++) ones = ones + OW'(hist_next[i]);
    result_next = shift ? int'(ones) >= THRESH : result;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist   <= '0;
      result <= 1'b0;
    end else if (ena && shift) begin
      hist   <= hist_next;
      result <= result_next;
    end
endmodule

// File: rtl/sense_cycle_scheduler.sv
// sense_cycle_scheduler: periodic trigger/echo/capture/inference sequencer feeding the harvest vote.
module sense_cycle_scheduler
  import sense_pkg::*;
#(
  parameter int PERIOD        = PERIOD_DEF,
  parameter int TRIG_CYCLES   = TRIG_CYCLES_DEF,
  parameter int ECHO_TIMEOUT  = ECHO_TIMEOUT_DEF,
  parameter int FRAME_TIMEOUT = FRAME_TIMEOUT_DEF,
  parameter int DIST_SHIFT    = DIST_SHIFT_DEF,
  parameter int VOTE_DEPTH    = VOTE_DEPTH_DEF,
  parameter int VOTE_THRESH   = VOTE_THRESH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       run,
  input  logic       echo_in,
  input  logic       frame_ready,
  input  logic       bnn_done,
  input  logic       bnn_pred,
  input  logic       uart_alert,
  output logic       trig_out,
  output logic       cap_en,
  output logic       bnn_start,
  output logic [7:0] distance,
  output logic       dist_valid,
  output logic       harvest,
  output logic       alarm,
  output logic [2:0] state_o,
  output logic       err_echo,
  output logic       err_frame,
  output logic       overrun
);
  localparam int EW = $clog2(ECHO_TIMEOUT + 1);
  state_t state, nstate;
  logic [CNT_W-1:0] pcnt, tcnt;
  logic [EW-1:0] ecnt, e_next;
  logic [31:0] e_dist;
  logic [7:0] dist_next;
  logic s1, s2, s3, pred, tick, rise, fall, h_next, dv_next, ee_next, ef_next;
  assign tick    = pcnt == CNT_W'(PERIOD - 1);
  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  // s3 is the edge-register copy of the echo, so the falling-edge cycle is still counted
  assign e_next  = ecnt + EW'(s3);
  assign e_dist  = 32'(e_next) >> DIST_SHIFT;
  assign state_o = state;
  always_comb begin
    nstate    = state;
    dist_next = distance;
    dv_next   = 1'b0;
    ee_next   = err_echo;
    ef_next   = err_frame;
    case (state)
      IDLE:      nstate = tick && run ? TRIG : IDLE;
      TRIG:      nstate = tcnt == CNT_W'(TRIG_CYCLES - 1) ? ECHO_WAIT : TRIG;
      ECHO_WAIT:
        if (rise) nstate = ECHO_MEAS;
        else if (tcnt == CNT_W'(ECHO_TIMEOUT - 1)) begin
          nstate  = FRAME;
          ee_next = 1'b1;
        end
      ECHO_MEAS:
        if (fall || tcnt == CNT_W'(ECHO_TIMEOUT - 1)) begin
          nstate    = FRAME;
          dv_next   = 1'b1;
          dist_next = !fall || e_dist > 32'd255 ? 8'd255 : e_dist[7:0];
          ee_next   = err_echo | ~fall;
        end
      FRAME:
        if (frame_ready) nstate = INFER;
        else if (tcnt == CNT_W'(FRAME_TIMEOUT - 1)) begin
          nstate  = IDLE;
          ef_next = 1'b1;
        end
      INFER:     nstate = bnn_done ? VOTE : INFER;
      VOTE:      nstate = IDLE;
      default:   nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      pcnt       <= '0;
      tcnt       <= '0;
      ecnt       <= '0;
      {s1, s2, s3, pred} <= '0;
      trig_out   <= 1'b0;
      cap_en     <= 1'b0;
      bnn_start  <= 1'b0;
      distance   <= '0;
      dist_valid <= 1'b0;
      alarm      <= 1'b0;
      err_echo   <= 1'b0;
      err_frame  <= 1'b0;
      overrun    <= 1'b0;
    end else if (ena) begin
      state      <= nstate;
      pcnt       <= tick ? '0 : pcnt + CNT_W'(1);
      tcnt       <= nstate != state ? '0 : tcnt + CNT_W'(1);
      ecnt       <= state == ECHO_MEAS ? e_next : '0;
      {s1, s2, s3} <= {echo_in, s1, s2};
      pred       <= state == INFER && bnn_done ? bnn_pred : pred;
      trig_out   <= nstate == TRIG;
      cap_en     <= nstate == FRAME;
      bnn_start  <= nstate == INFER && state != INFER;
      distance   <= dist_next;
      dist_valid <= dv_next;
      alarm      <= h_next | uart_alert;
      err_echo   <= ee_next;
      err_frame  <= ef_next;
      overrun    <= overrun | (tick && state != IDLE);
    end
  majority_vote_filter #(.DEPTH(VOTE_DEPTH), .THRESH(VOTE_THRESH)) u_vote (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .shift(state == VOTE),
    .bit_in(pred),
    .result(harvest),
    .result_next(h_next)
  );
endmodule

// File: tb/tb_sense_cycle_scheduler.sv
// tb_sense_cycle_scheduler: randomized measurement cycles checked by a queue scoreboard against a vote/distance model.
module tb_sense_cycle_scheduler;
  localparam int PERIOD = 1000, TRIG = 10, ETO = 200, FTO = 300, SH = 2;
  typedef struct {logic [3:0] hist; logic harvest;} vote_t;
  logic clk = 0, rst, ena = 1, run = 0, echo_in = 0, frame_ready = 0, bnn_done = 0, bnn_pred = 0, uart_alert = 0;
  logic trig_out, cap_en, bnn_start, dist_valid, harvest, alarm, err_echo, err_frame, overrun;
  logic [7:0] distance;
  logic [2:0] state_o;
  int vectors = 0, miscompares = 0;
  int dist_q[$];
  vote_t vote_q[$];
  vote_t vexp;
  bit preds[$];
  int last_dist = 0, starts_exp = 0, starts_seen = 0, trig_w = 0, cyc = 0, launch_cyc = 0;
  bit x_ee = 0, x_ef = 0, x_ov = 0, in_vote = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sense_cycle_scheduler #(
    .PERIOD(PERIOD), .TRIG_CYCLES(TRIG), .ECHO_TIMEOUT(ETO), .FRAME_TIMEOUT(FTO),
    .DIST_SHIFT(SH), .VOTE_DEPTH(4), .VOTE_THRESH(3)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .run(run), .echo_in(echo_in), .frame_ready(frame_ready),
    .bnn_done(bnn_done), .bnn_pred(bnn_pred), .uart_alert(uart_alert), .trig_out(trig_out),
    .cap_en(cap_en), .bnn_start(bnn_start), .distance(distance), .dist_valid(dist_valid),
    .harvest(harvest), .alarm(alarm), .state_o(state_o), .err_echo(err_echo),
    .err_frame(err_frame), .overrun(overrun)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference vote: newest prediction is bit 0, harvest when at least 3 of the last 4 are ones
  function automatic logic [3:0] model_hist();
    logic [3:0] h = '0;
    for (int i = 0; i < 4 && i < preds.size(); i++) h[i] = preds[preds.size() - 1 - i];
    return h;
  endfunction

  function automatic vote_t model_vote(input bit p);
    vote_t v;
    int ones = 0;
    preds.push_back(p);
    v.hist = model_hist();
    for (int i = 0; i < 4; i++) ones += int'(v.hist[i]);
    v.harvest = ones >= 3;
    return v;
  endfunction

  function automatic logic sig(input int k);
    return k == 0 ? trig_out : k == 1 ? cap_en : bnn_start;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input string name, input int k, input logic v, input int limit, output int n);
    n = 0;
    while (sig(k) !== v && n < limit) begin
      tick();
      n++;
    end
    check(name, sig(k), v);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, state_o, 0);
    check({tag, "_trig"}, trig_out, 0);
    check({tag, "_cap"}, cap_en, 0);
    check({tag, "_start"}, bnn_start, 0);
    check({tag, "_dist"}, distance, 0);
    check({tag, "_dv"}, dist_valid, 0);
    check({tag, "_harvest"}, harvest, 0);
    check({tag, "_alarm"}, alarm, 0);
    check({tag, "_errs"}, {err_echo, err_frame, overrun}, 0);
    check({tag, "_hist"}, dut.u_vote.hist, 0);
  endtask

  // el: echo high length (0 = no echo, <0 = stuck high); fd: frame delay (<0 = never); dd: done delay (<0 = stop in INFER)
  task automatic run_cycle(input int ed, input int el, input int fd, input int dd, input bit p, input int gap);
    int n, d;
    wait_sig("launch", 0, 1, PERIOD + 100, n);
    launch_cyc = cyc;
    if (gap > 0) begin
      repeat (3) tick();
      ena = 0;
      repeat (gap) tick();
      check("trig_frozen", trig_out, 1);
      ena = 1;
    end
    wait_sig("trig_end", 0, 0, TRIG + 20, n);
    repeat (ed) tick();
    if (el != 0) begin
      d = el > 0 ? ((el >> SH) > 255 ? 255 : el >> SH) : 255;
      dist_q.push_back(d);
      last_dist = d;
      echo_in = 1;
      if (el > 0) begin
        repeat (el) tick();
        echo_in = 0;
      end
    end
    if (el <= 0) x_ee = 1;
    wait_sig("frame_open", 1, 1, 2 * ETO + 40, n);
    echo_in = 0;
    if (fd < 0) begin
      x_ef = 1;
      wait_sig("frame_close", 1, 0, FTO + 40, n);
      check("frame_timeout_len", n, FTO);
      check("frame_to_idle", state_o, 0);
      check("frame_no_start", bnn_start, 0);
      check("hist_hold", dut.u_vote.hist, model_hist());
    end else begin
      repeat (fd) tick();
      frame_ready = 1;
      tick();
      frame_ready = 0;
      check("cap_drop", cap_en, 0);
      wait_sig("bnn_start", 2, 1, 4, n);
      starts_exp++;
      if (dd < 0) return;
      repeat (dd) tick();
      if (dd >= PERIOD) x_ov = 1;
      bnn_pred = p;
      bnn_done = 1;
      vote_q.push_back(model_vote(p));
      tick();
      bnn_done = 0;
      bnn_pred = 0;
    end
    repeat (3) tick();
    check("cycle_idle", state_o, 0);
    check("distance_hold", distance, last_dist);
    check("err_echo", err_echo, x_ee);
    check("err_frame", err_frame, x_ef);
    check("overrun", overrun, x_ov);
    check("bnn_start_count", starts_seen, starts_exp);
  endtask

  always @(negedge clk) begin
    if (in_vote) begin
      if (vote_q.size() == 0) check("vote_unexpected", 1, 0);
      else begin
        vexp = vote_q.pop_front();
        check("hist", dut.u_vote.hist, vexp.hist);
        check("harvest", harvest, vexp.harvest);
        check("alarm", alarm, vexp.harvest);
      end
    end
    in_vote = !rst && ena && state_o == 3'd6;
    if (dist_valid && ena) begin
      if (dist_q.size() == 0) check("dist_unexpected", 1, 0);
      else check("distance", distance, dist_q.pop_front());
    end
    if (bnn_start && ena) starts_seen++;
    if (trig_out && ena) trig_w++;
    else if (!trig_out && trig_w > 0) begin
      check("trig_width", trig_w, TRIG);
      trig_w = 0;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run did not finish, %0d miscompares so far", miscompares);
    $fatal(1);
  end

  initial begin
    int n;
    rst = 0;
    #2 rst = 1;
    repeat (3) tick();
    check_reset("por");
    run = 1;
    rst = 0;
    wait_sig("first_launch", 0, 1, PERIOD + 100, n);
    check("first_launch_wait", n, PERIOD);
    run_cycle(5, 80, 50, 4, 1, 0);
    run_cycle(5, 80, 50, 4, 1, 0);
    run_cycle(5, 80, 50, 4, 0, 0);
    run_cycle(5, 80, 50, 4, 1, 0);
    run_cycle(5, 80, 50, 4, 0, 0);
    run_cycle(5, 0, 20, 3, 1, 0);
    run_cycle(5, -1, 20, 3, 1, 0);
    run_cycle(5, 80, -1, 0, 0, 0);
    run_cycle(7, 40, 10, 2, 1, 50);
    for (int i = 0; i < 12; i++) begin
      int r, el, fd;
      r  = $urandom_range(0, 9);
      el = r == 0 ? 0 : r == 1 ? -1 : $urandom_range(4, 150);
      fd = $urandom_range(0, 7) == 0 ? -1 : $urandom_range(0, 250);
      run_cycle($urandom_range(1, 100), el, fd, $urandom_range(0, 20), 1'($urandom_range(0, 1)), 0);
    end
    run_cycle(5, 80, 50, 1200, 1, 0);
    n = launch_cyc;
    wait_sig("relaunch", 0, 1, 2 * PERIOD, launch_cyc);
    check("lost_launch_gap", cyc - n, 2 * PERIOD);
    run_cycle(5, 80, 50, -1, 0, 0);
    repeat (3) tick();
    rst = 1;
    #1;
    check_reset("rst_infer");
    tick();
    rst = 0;
    preds.delete();
    last_dist = 0;
    {x_ee, x_ef, x_ov} = '0;
    wait_sig("launch_after_rst", 0, 1, PERIOD + 100, n);
    check("rst_launch_wait", n, PERIOD);
    uart_alert = 1;
    check("alarm_latency", alarm, 0);
    tick();
    check("alarm_uart", alarm, 1);
    uart_alert = 0;
    tick();
    check("alarm_clear", alarm, 0);
    run_cycle(5, 60, 30, 4, 1, 0);
    run_cycle(9, 120, 5, 1, 1, 0);
    check("dist_q_drained", dist_q.size(), 0);
    check("vote_q_drained", vote_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sense_cycle_scheduler.md
# sense_cycle_scheduler

Periodic measurement sequencer for the microgreen harvest classifier. Each cycle it fires the ultrasonic trigger, times the echo into a distance, opens a one-frame camera capture window, launches one BNN inference, and folds the prediction into an N-of-M vote. The vote result drives the harvest alarm. It sits between the sensor front-ends (camera feature accumulator, ultrasonic pin) and the BNN core. It replaces their free-running, unsequenced operation.

## Interface
Parameters:
- PERIOD, 1500000: clock cycles between cycle launches (21-bit counter).
- TRIG_CYCLES, 250: trigger pulse width in cycles.
- ECHO_TIMEOUT, 60000: maximum cycles in each echo state.
- FRAME_TIMEOUT, 1048575: maximum cycles waiting for frame_ready.
- DIST_SHIFT, 10: echo_count right-shift giving distance units.
- VOTE_DEPTH, 4: prediction history length.
- VOTE_THRESH, 3: number of 1s in the history needed to assert harvest.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset; asynchronous, active-high.
- ena  in  1  global enable; low freezes all state, counters and outputs.
- run  in  1  enables periodic launches.
- echo_in  in  1  raw ultrasonic echo; 2-flop synchronized internally.
- frame_ready  in  1  one-cycle pulse from the feature accumulator.
- bnn_done  in  1  one-cycle pulse from the BNN core.
- bnn_pred  in  1  BNN prediction, sampled when bnn_done=1.
- uart_alert  in  1  external override.
- trig_out  out  1  ultrasonic trigger.
- cap_en  out  1  capture window for the accumulator.
- bnn_start  out  1  one-cycle inference launch.
- distance  out  8  last measured distance.
- dist_valid  out  1  one-cycle pulse when distance updates.
- harvest  out  1  vote result.
- alarm  out  1  registered (harvest | uart_alert).
- state_o  out  3  current FSM state encoding.
- err_echo, err_frame, overrun  out  1 each  sticky error flags, cleared only by rst.

## Operation
- States: IDLE=0, TRIG=1, ECHO_WAIT=2, ECHO_MEAS=3, FRAME=4, INFER=5, VOTE=6.
- Period counter: free-runs 0..PERIOD-1 whenever ena=1. At count PERIOD-1:
  - IDLE & run: go to TRIG.
  - Not IDLE: set overrun; no launch (the tick is lost).
  - run=0: no action.
- TRIG: trig_out=1 for exactly TRIG_CYCLES cycles, then ECHO_WAIT.
- ECHO_WAIT: a synchronized echo rising edge goes to ECHO_MEAS with echo_count=0. Timeout: set err_echo, go to FRAME; distance unchanged, no dist_valid.
- ECHO_MEAS: echo_count increments while echo high.
  - Falling edge: distance=min(echo_count>>DIST_SHIFT,255), pulse dist_valid, go to FRAME.
  - Timeout: distance=255, err_echo set, dist_valid pulsed, go to FRAME.
- FRAME: cap_en=1.
  - frame_ready: go to INFER.
  - Timeout: set err_frame, go to IDLE; no inference, no vote.
- INFER: bnn_start pulses on the first INFER cycle only. bnn_done latches bnn_pred and goes to VOTE. No timeout.
- VOTE: one cycle.
  - hist <= {hist[VOTE_DEPTH-2:0], pred}.
  - harvest <= popcount(new hist) >= VOTE_THRESH.
  - Return to IDLE.
- Event filtering: frame_ready and bnn_done outside their waiting state are ignored.
- Simultaneous events: frame_ready on the same cycle as the FRAME timeout counts as a success.
- Reset values:
  - State IDLE; all counters 0; hist=0.
  - distance=0, and dist_valid, trig_out, cap_en, bnn_start, harvest, alarm, all error flags = 0.
- Reset mid-cycle: immediate return to IDLE; outputs drop asynchronously.
- run deasserted mid-cycle: the current cycle completes; no further launches.

## Timing
- All outputs are registered.
- Launch: trig_out rises the cycle after the period counter reads PERIOD-1.
- Echo: edge detection lags the echo pin by 2 cycles (synchronizer) plus 1 cycle (edge register).
- Timeout counters reset on every state entry. A timeout fires when the counter reaches the limit-1 without the awaited event.
- bnn_start aligns with the first INFER cycle; cap_en deasserts on the cycle after frame_ready.
- harvest and alarm update 1 cycle after VOTE; uart_alert reaches alarm with 1-cycle latency.
- While ena=0, pulses do not extend: a pulse pending under ena=0 resumes on re-enable.

## Structure
- Shared package sense_pkg holds:
  - the state enum (3-bit encoding above);
  - default constants for PERIOD, TRIG_CYCLES, ECHO_TIMEOUT, FRAME_TIMEOUT, DIST_SHIFT, VOTE_DEPTH and VOTE_THRESH.
- Sub-module majority_vote_filter holds the shift history, popcount and threshold compare, with shift-enable, bit-in and result-out ports.
- The synchronizer, FSM, period counter and timeout counter stay in the top module.

## Test plan
All scenarios use PERIOD=1000, TRIG_CYCLES=10, ECHO_TIMEOUT=200, FRAME_TIMEOUT=300, DIST_SHIFT=2.
- Nominal cycle: echo rises 5 cycles after trigger and stays high 80 cycles; frame_ready after 50; bnn_done with pred=1 after 4. Required: trig_out high exactly 10 cycles, distance=20 with one dist_valid pulse, exactly one bnn_start, hist=0001, harvest=0.
- Vote: four cycles with pred=1,1,0,1 give harvest=1 after the 4th VOTE. A following pred=0 drops harvest to 0 (hist 1010).
- Echo timeouts:
  - No echo: err_echo=1, distance unchanged, FSM proceeds to FRAME.
  - Echo stuck high: distance=255, dist_valid pulsed.
- Frame timeout: frame_ready never arrives. Required: err_frame=1, no bnn_start, hist unchanged, FSM back in IDLE 300 cycles after entering FRAME.
- Overrun and ena: bnn_done withheld 1200 cycles gives overrun=1 and exactly one launch lost. ena low for 50 cycles mid-TRIG still yields trig_out high for exactly 10 enabled cycles.
- Reset and override: rst asserted during INFER forces all outputs to their reset values immediately, and the next launch waits for the period wrap. uart_alert=1 with harvest=0 gives alarm=1 one cycle later.
